// File: rtl/pattern_scanner_pkg.sv
// Shared definitions for the pattern scanner, its ROM and the .mem generator.
// One ROM entry describes one inclusive rectangle in pixel coordinates.
package pattern_scanner_pkg;

    localparam int ENT_W     = 38;
    localparam int N_ENT_DEF = 30;
    localparam int N_PAT_DEF = 8;

    typedef struct packed {
        logic [9:0] x0;
        logic [8:0] y0;
        logic [9:0] x1;
        logic [8:0] y1;
    } rect_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

endpackage

// File: rtl/pattern_scanner_rect_hit.sv
// Single-rectangle hit test with inclusive, unsigned bounds.
// Inverted bounds (x0>x1 or y0>y1) can never satisfy both compares.
module rect_hit
    import pattern_scanner_pkg::*;
(
    input  rect_t      ent,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic       hit
);

    logic in_x;
    logic in_y;

    assign in_x = (ent.x0 <= x) && (x <= ent.x1);
    assign in_y = (ent.y0 <= y) && (y <= ent.y1);
    assign hit  = in_x && in_y;

endmodule

// File: rtl/pattern_scanner.sv
// Loads one pattern of rectangles from ROM and flags pixels that fall
// inside any loaded rectangle, one cycle after the coordinate is presented.
module pattern_scanner
    import pattern_scanner_pkg::*;
#(
    parameter int N_ENT = N_ENT_DEF,
    parameter int N_PAT = N_PAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [2:0]       pat_sel,
    input  logic [9:0]       x_pixel,
    input  logic [8:0]       y_pixel,
    output logic             p_oe,
    output logic [7:0]       p_Addr,
    input  logic [ENT_W-1:0] p_Data,
    output logic             pix_on,
    output logic             busy,
    output logic             load_done
);

    localparam int IW = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_ENT - 1);

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic          loaded_q, loaded_d;
    logic          pix_on_q, pix_on_d;

    logic [7:0]       fetch_addr;
    logic [N_ENT-1:0] hit;
    rect_t            ent_q [N_ENT];

    assign fetch_addr = 8'(sel_q) * 8'(N_ENT) + 8'(idx_q);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wr_d      = 1'b0;
        wr_idx_d  = wr_idx_q;
        loaded_d  = loaded_q;
        p_oe      = 1'b0;
        p_Addr    = addr_q;
        busy      = 1'b1;
        load_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (frame_start) begin
                    // Out-of-range selections fall back to the last pattern
                    sel_d   = (int'(pat_sel) < N_PAT) ? pat_sel
                                                      : 3'(N_PAT - 1);
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                p_oe     = 1'b1;
                p_Addr   = fetch_addr;
                addr_d   = fetch_addr;
                wr_d     = 1'b1;
                wr_idx_d = idx_q;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                load_done = 1'b1;
                loaded_d  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pix_on_d = loaded_q && (|hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wr_idx_q <= '0;
            loaded_q <= 1'b0;
            pix_on_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wr_idx_q <= wr_idx_d;
            loaded_q <= loaded_d;
            pix_on_q <= pix_on_d;
        end
    end

    assign pix_on = pix_on_q;

    // Entry storage is not reset; loaded_q masks stale contents instead
    for (genvar i = 0; i < N_ENT; i++) begin : g_ent
        always_ff @(posedge clk) begin
            if (wr_q && (wr_idx_q == IW'(i))) begin
                ent_q[i] <= rect_t'(p_Data);
            end
        end

        rect_hit u_hit (
            .ent (ent_q[i]),
            .x   (x_pixel),
            .y   (y_pixel),
            .hit (hit[i])
        );
    end

endmodule

// File: tb/tb_pattern_scanner.sv
// Directed plus randomized bench for pattern_scanner with a ROM model and
// a rectangle-list reference for pixel hits.
module tb_pattern_scanner;
    import pattern_scanner_pkg::*;

    localparam int NE = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [2:0]  pat_sel = '0;
    logic [9:0]  x_pixel = '0;
    logic [8:0]  y_pixel = '0;
    logic        p_oe;
    logic [7:0]  p_Addr;
    logic [37:0] p_Data = '0;
    logic        pix_on;
    logic        busy;
    logic        load_done;

    int vectors = 0;
    int miscompares = 0;

    rect_t rom [256];
    rect_t mdl [NE];
    bit    mdl_loaded = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (p_oe) p_Data <= rom[p_Addr];
    end

    pattern_scanner #(.N_ENT(NE), .N_PAT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pat_sel     (pat_sel),
        .x_pixel     (x_pixel),
        .y_pixel     (y_pixel),
        .p_oe        (p_oe),
        .p_Addr      (p_Addr),
        .p_Data      (p_Data),
        .pix_on      (pix_on),
        .busy        (busy),
        .load_done   (load_done)
    );

    function automatic rect_t mk(int x0, int y0, int x1, int y1);
        rect_t r;
        r.x0 = 10'(x0);
        r.y0 = 9'(y0);
        r.x1 = 10'(x1);
        r.y1 = 9'(y1);
        return r;
    endfunction

    function automatic bit ref_pix(int x, int y);
        if (!mdl_loaded) return 1'b0;
        foreach (mdl[i]) begin
            if (x >= int'(mdl[i].x0) && x <= int'(mdl[i].x1) &&
                y >= int'(mdl[i].y0) && y <= int'(mdl[i].y1))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pix(int x, int y, int exp);
        x_pixel = 10'(x);
        y_pixel = 9'(y);
        @(negedge clk);
        chk("pix_on", 32'(pix_on), 32'(exp));
    endtask

    // Starts at a negedge; returns at a negedge with the load finished
    // (or aborted by reset when rst_at >= 0).
    task automatic load(int pat, int rep_at, int rst_at);
        frame_start = 1'b1;
        pat_sel     = 3'(pat);
        for (int k = 0; k < NE; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            chk("fetch_addr", 32'(p_Addr), 32'(pat * NE + k));
            chk("fetch_oe", 32'(p_oe), 1);
            chk("fetch_busy", 32'(busy), 1);
            chk("fetch_done", 32'(load_done), 0);
            if (k == rep_at) begin
                frame_start = 1'b1;
                pat_sel     = 3'd5;
            end
            if (k == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("abort_oe", 32'(p_oe), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_done", 32'(load_done), 0);
                chk("abort_pix", 32'(pix_on), 0);
                chk("abort_addr", 32'(p_Addr), 0);
                reset      = 1'b0;
                mdl_loaded = 1'b0;
                return;
            end
        end
        @(negedge clk);
        chk("drain_done", 32'(load_done), 1);
        chk("drain_busy", 32'(busy), 1);
        chk("drain_oe", 32'(p_oe), 0);
        chk("drain_addr", 32'(p_Addr), 32'(pat * NE + NE - 1));
        for (int i = 0; i < NE; i++) mdl[i] = rom[pat * NE + i];
        mdl_loaded = 1'b1;
        @(negedge clk);
        chk("idle_done", 32'(load_done), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic rand_pix(int n);
        for (int v = 0; v < n; v++) begin
            int x;
            int y;
            if ($urandom_range(0, 1) == 0) begin
                rect_t r;
                r = mdl[$urandom_range(0, NE - 1)];
                x = ($urandom_range(0, 1) ? int'(r.x0) : int'(r.x1))
                    + int'($urandom_range(0, 2)) - 1;
                y = ($urandom_range(0, 1) ? int'(r.y0) : int'(r.y1))
                    + int'($urandom_range(0, 2)) - 1;
                x = (x < 0) ? 0 : (x > 1023) ? 1023 : x;
                y = (y < 0) ? 0 : (y > 511) ? 511 : y;
            end else begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 511));
            end
            pix(x, y, int'(ref_pix(x, y)));
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = mk(1023, 0, 0, 511);
        rom[60] = mk(100, 50, 199, 149);
        rom[61] = mk(300, 0, 10, 511);
        for (int a = 150; a < 240; a++) begin
            int x0;
            int y0;
            if (a >= 180 && a < 210) continue;
            x0 = int'($urandom_range(0, 900));
            y0 = int'($urandom_range(0, 450));
            rom[a] = mk(x0, y0, x0 + int'($urandom_range(0, 120)),
                        y0 + int'($urandom_range(0, 60)));
            if ($urandom_range(0, 4) == 0)
                rom[a] = mk(x0 + 5, y0, x0, y0 + 10);
        end

        repeat (2) @(negedge clk);
        chk("rst_oe", 32'(p_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_pix", 32'(pix_on), 0);
        chk("rst_addr", 32'(p_Addr), 0);
        reset = 1'b0;
        pix(150, 100, 0);

        load(2, -1, -1);
        pix(100, 50, 1);
        pix(199, 149, 1);
        pix(99, 50, 0);
        pix(200, 149, 0);
        for (int x = 0; x < 1024; x += 31) pix(x, 200, 0);
        pix(10, 200, 0);
        pix(300, 200, 0);

        load(2, -1, 15);
        pix(150, 100, 0);
        load(2, -1, -1);
        pix(150, 100, 1);

        load(2, 10, -1);
        pix(150, 100, 1);
        pix(250, 100, 0);

        load(5, -1, -1);
        rand_pix(40);
        load(7, -1, -1);
        rand_pix(80);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
